// File: rtl/axi_lite_imem_rsp.sv
// axi_lite_imem_rsp
//   AXI-lite read-channel responder acting as the instruction/data memory
//   behind the fetch arbiter. One AR request is accepted at a time; after a
//   fixed (or, optionally, pseudo-random) latency a single R beat is returned
//   with data and response code. The word array is filled through a backdoor
//   load port and is never reset.
//
//   Optional build macro: AXI_LITE_IMEM_RAND_LAT_EN
//     defined   -> a 16-bit Galois LFSR adds 0..7 extra cycles per request
//     undefined -> latency is exactly LATENCY
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   araddr_i     read address
//   arvalid_i    read address valid
//   arready_o    read address ready (high only in IDLE)
//   rvalid_o     read data valid (high only in RESP)
//   rdata_o      registered read data
//   rresp_o      00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range)
//   rready_i     read data ready
//   load_en_i    backdoor write strobe
//   load_idx_i   backdoor word index
//   load_data_i  backdoor write data
//   busy_o       transaction in flight (state != IDLE)

module axi_lite_imem_rsp #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    DEPTH_WORDS = 4096,
  parameter int                    LATENCY     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic                           rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  input  logic                           rready_i,
  input  logic                           load_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx_i,
  input  logic [DATA_WIDTH-1:0]          load_data_i,
  output logic                           busy_o
);

  // state | meaning
  // ------+-------------------------------------------------------------
  // IDLE  | ready for an AR handshake
  // WAIT  | request latched, counting down the access latency
  // RESP  | R beat presented, held until rready_i

  localparam int IDX_W      = $clog2(DEPTH_WORDS);
  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int OFF_LSB    = $clog2(WORD_BYTES);
  localparam int WOFF_W     = ADDR_WIDTH - OFF_LSB;
  // Wide enough for LATENCY (max 15) plus the optional 0..7 random extra.
  localparam int CNT_W      = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       lat_eff;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  addr_src;
  logic [WOFF_W-1:0]      word_off;
  logic                   misaligned;
  logic                   out_of_range;
  logic [IDX_W-1:0]       word_idx;
  logic                   ar_hs;
  logic                   rsp_entry;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [1:0]             rresp_q;

  logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

`ifdef AXI_LITE_IMEM_RAND_LAT_EN
  logic [15:0] lfsr;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign lat_eff = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
  assign lat_eff = CNT_W'(LATENCY);
`endif

  assign ar_hs = arvalid_i & arready_o;

  // With zero effective latency the RESP-entry edge is the handshake edge
  // itself, so the response must come from the live address, not addr_q.
  assign addr_src     = (state == S_IDLE) ? araddr_i : addr_q;
  // Word-granular offset; BASE_ADDR is word aligned so the low bits drop out.
  assign word_off     = addr_src[ADDR_WIDTH-1:OFF_LSB] - BASE_ADDR[ADDR_WIDTH-1:OFF_LSB];
  assign misaligned   = |addr_src[OFF_LSB-1:0];
  assign out_of_range = |word_off[WOFF_W-1:IDX_W];
  assign word_idx     = word_off[IDX_W-1:0];
  assign rsp_entry    = (state != S_RESP) && (state_nxt == S_RESP);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (arvalid_i) state_nxt = (lat_eff == '0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == '0) state_nxt = S_RESP;
      S_RESP: if (rready_i)  state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    arready_o = (state == S_IDLE);
    rvalid_o  = (state == S_RESP);
    busy_o    = (state != S_IDLE);
  end

  assign rdata_o = rdata_q;
  assign rresp_o = rresp_q;

  // Address latch, latency down-counter and registered response.
  // The array read here sees the pre-edge contents, so a backdoor load to the
  // same word on the RESP-entry edge returns the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        addr_q <= araddr_i;
        cnt    <= (lat_eff == '0) ? '0 : lat_eff - CNT_W'(1);
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (rsp_entry) begin
        if (misaligned) begin
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end else if (out_of_range) begin
          rresp_q <= RESP_DECERR;
          rdata_q <= '0;
        end else begin
          rresp_q <= RESP_OKAY;
          rdata_q <= mem[word_idx];
        end
      end
    end
  end

  // Backdoor load port; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_idx_i] <= load_data_i;
    end
  end

endmodule
